// File: rtl/led_seq_arb.sv
// led_seq_arb: two-requester LED sequencer.
// Channel 0 (alarm) has priority and, while it owns an active sequence,
// locks out channel 1 (host). A clock-enable prescaler produces a tick
// every TICK_DIV clks. Each tick advances a step counter, and the step
// counter drives the OFF/STATIC/BLINK/RUN sequencing of an 8-bit LED bank.
// Optional feature macro: LED_DIM_EN. When it is defined, a 16-slot PWM
// dimmer is added on the LED output, with DIM_DUTY on-slots out of 16.
module led_seq_arb #(
  parameter int TICK_DIV = 1000000,
  parameter int DIV_W    = 20
`ifdef LED_DIM_EN
  ,
  parameter int DIM_DUTY = 8
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd0_valid,
  output logic       cmd0_ready,
  input  logic [1:0] cmd0_mode,
  input  logic [7:0] cmd0_pattern,
  input  logic [7:0] cmd0_period,
  input  logic       cmd1_valid,
  output logic       cmd1_ready,
  input  logic [1:0] cmd1_mode,
  input  logic [7:0] cmd1_pattern,
  input  logic [7:0] cmd1_period,
  output logic [7:0] led,
  output logic       tick,
  output logic       owner,
  output logic       busy
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_RUN    = 2'd3
  } mode_e;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  // Prescaler
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  // Sequencer state
  mode_e      state_q, state_d;
  logic [7:0] pattern_q, pattern_d;
  logic [7:0] period_q, period_d;
  logic [7:0] step_q, step_d;
  logic [7:0] led_state_q, led_state_d;
  logic       owner_q, owner_d;
  logic       busy_q, busy_d;

  // Handshake and selected command
  logic       lock_s;
  logic       acc0_s, acc1_s, accept_s;
  logic [1:0] cmd_mode_s;
  logic [7:0] cmd_pattern_s, cmd_period_s;
  logic [7:0] step_last_s;
  logic       step_evt_s;

  // Alarm lock: an active channel-0 sequence blocks the host. Channel 1 is
  // also refused on any cycle where channel 0 presents a command.
  assign lock_s     = ~owner_q & busy_q;
  assign cmd0_ready = ~reset;
  assign cmd1_ready = ~reset & ~lock_s & ~cmd0_valid;
  assign acc0_s     = cmd0_valid & cmd0_ready;
  assign acc1_s     = cmd1_valid & cmd1_ready;
  assign accept_s   = acc0_s | acc1_s;

  // Select the winning command fields (channel 0 has priority)
  always_comb begin
    cmd_mode_s    = cmd1_mode;
    cmd_pattern_s = cmd1_pattern;
    cmd_period_s  = cmd1_period;
    if (acc0_s) begin
      cmd_mode_s    = cmd0_mode;
      cmd_pattern_s = cmd0_pattern;
      cmd_period_s  = cmd0_period;
    end else begin
      cmd_mode_s    = cmd1_mode;
      cmd_pattern_s = cmd1_pattern;
      cmd_period_s  = cmd1_period;
    end
  end

  // Free-running prescaler. The tick is registered so that it is high on
  // the cycle where the count equals TICK_DIV-1.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_ONE;
    end
    tick_d = (div_d == DIV_LAST);
  end

  // A period of 0 behaves as 1. A step event fires on the tick that
  // completes the period.
  always_comb begin
    step_last_s = 8'd0;
    if (period_q == 8'd0) begin
      step_last_s = 8'd0;
    end else begin
      step_last_s = period_q - 8'd1;
    end
    step_evt_s = tick_q & (step_q == step_last_s);
  end

  // Next-state logic. An accepted command replaces everything, and it also
  // swallows a coincident tick.
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    period_d    = period_q;
    step_d      = step_q;
    led_state_d = led_state_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    if (accept_s) begin
      state_d     = mode_e'(cmd_mode_s);
      pattern_d   = cmd_pattern_s;
      period_d    = cmd_period_s;
      step_d      = 8'd0;
      owner_d     = ~acc0_s;
      busy_d      = (cmd_mode_s != 2'd0);
      led_state_d = (cmd_mode_s == 2'd0) ? 8'd0 : cmd_pattern_s;
    end else begin
      if (tick_q) begin
        step_d = step_evt_s ? 8'd0 : (step_q + 8'd1);
      end else begin
        step_d = step_q;
      end
      case (state_q)
        MODE_OFF:    led_state_d = 8'd0;
        MODE_STATIC: led_state_d = pattern_q;
        MODE_BLINK: begin
          if (step_evt_s) begin
            led_state_d = (led_state_q == 8'd0) ? pattern_q : 8'd0;
          end else begin
            led_state_d = led_state_q;
          end
        end
        MODE_RUN: begin
          if (step_evt_s) begin
            led_state_d = {led_state_q[6:0], led_state_q[7]};
          end else begin
            led_state_d = led_state_q;
          end
        end
        default:     led_state_d = 8'd0;
      endcase
    end
  end

  // State registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      tick_q      <= 1'b0;
      state_q     <= MODE_OFF;
      pattern_q   <= 8'd0;
      period_q    <= 8'd0;
      step_q      <= 8'd0;
      led_state_q <= 8'd0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      tick_q      <= tick_d;
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      period_q    <= period_d;
      step_q      <= step_d;
      led_state_q <= led_state_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
    end
  end

  assign tick  = tick_q;
  assign owner = owner_q;
  assign busy  = busy_q;

`ifdef LED_DIM_EN
  localparam logic [4:0] DUTY_C = (DIM_DUTY >= 16) ? 5'd16 :
                                  ((DIM_DUTY <= 0) ? 5'd0 : 5'(DIM_DUTY));

  logic [3:0] pwm_q;

  // Free-running 16-slot PWM counter for the dimmer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end

  assign led = led_state_q & {8{({1'b0, pwm_q} < DUTY_C)}};
`else
  assign led = led_state_q;
`endif

endmodule
